// File: rtl/spi_ram_ctrl_if.sv
// Request/response bus between the core and the SPI SRAM controller.
// master = core side, slave = controller side.
interface spi_ram_ctrl_if #(
  parameter int ADDR_BYTES = 3
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [8*ADDR_BYTES-1:0] req_addr;
  logic [3:0]              req_wmask;
  logic [31:0]             req_wdata;
  logic                    rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// SPI mode-0 SRAM controller: word reads, byte/half/word masked writes,
// optional WRMR sequential-mode init after reset.
//
// state      | meaning
// S_INIT     | first cycle out of reset; launch WRMR frame or go idle
// S_IDLE     | req_ready high, waiting for a request
// S_CS_SETUP | cs_n low, SCK low, DIV cycles before the first bit
// S_SHIFT    | per bit: DIV cycles SCK low, DIV cycles SCK high
// S_CS_HOLD  | last bit done, SCK low DIV cycles before cs_n rises
// S_REJECT   | illegal write mask, no SPI activity
// S_RESP     | rsp_valid pulse cycle
// S_GAP      | cs_n held high CS_GAP cycles before accepting again
module spi_ram_ctrl #(
  parameter int ADDR_BYTES = 3,
  parameter int DIV        = 1,
  parameter int CS_GAP     = 2,
  parameter int INIT_MODE  = 1
) (
  input  logic           clk,
  input  logic           rst,
  spi_ram_ctrl_if.slave  bus,
  output logic           spi_clk,
  output logic           spi_cs_n,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int SR_W  = 8 + AW + 32;
  localparam int NB_W  = $clog2(SR_W + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_REJECT, S_RESP, S_GAP
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [NB_W-1:0]   nbits;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [31:0]       rx;
  logic              is_init;
  logic              is_read;

  logic              mask_legal;
  logic [1:0]        mask_start;
  logic [2:0]        mask_bytes;
  logic [1:0]        start_eff;
  logic [2:0]        n_data;
  logic [31:0]       wshift;
  logic [31:0]       data_field;
  logic [AW-1:0]     frame_addr;
  logic [7:0]        frame_cmd;
  logic [SR_W-1:0]   frame;
  logic [NB_W-1:0]   frame_bits;
  logic              div_last;

  always_comb begin
    mask_legal = 1'b1;
    mask_start = 2'd0;
    mask_bytes = 3'd4;
    case (bus.req_wmask)
      4'b0001: begin mask_start = 2'd0; mask_bytes = 3'd1; end
      4'b0010: begin mask_start = 2'd1; mask_bytes = 3'd1; end
      4'b0100: begin mask_start = 2'd2; mask_bytes = 3'd1; end
      4'b1000: begin mask_start = 2'd3; mask_bytes = 3'd1; end
      4'b0011: begin mask_start = 2'd0; mask_bytes = 3'd2; end
      4'b1100: begin mask_start = 2'd2; mask_bytes = 3'd2; end
      4'b1111: begin mask_start = 2'd0; mask_bytes = 3'd4; end
      default: mask_legal = 1'b0;
    endcase
  end

  // Reads always fetch the whole aligned word; writes start at the first enabled byte.
  always_comb begin
    start_eff  = bus.req_we ? mask_start : 2'd0;
    n_data     = bus.req_we ? mask_bytes : 3'd4;
    wshift     = bus.req_wdata >> {start_eff, 3'b000};
    data_field = bus.req_we ? {wshift[7:0], wshift[15:8], wshift[23:16], wshift[31:24]} : 32'h0;
    frame_addr = (bus.req_addr & ~AW'(3)) | AW'(start_eff);
    frame_cmd  = bus.req_we ? 8'h02 : 8'h03;
    frame      = {frame_cmd, frame_addr, data_field};
    frame_bits = NB_W'(8 + AW + 8 * int'(n_data));
  end

  assign div_last = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INIT;
      sr            <= '0;
      nbits         <= '0;
      div_cnt       <= '0;
      gap_cnt       <= '0;
      rx            <= '0;
      is_init       <= 1'b0;
      is_read       <= 1'b0;
      spi_clk       <= 1'b0;
      spi_cs_n      <= 1'b1;
      spi_mosi      <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (INIT_MODE != 0) begin
            sr       <= {16'h0140, {(SR_W - 16){1'b0}}};
            nbits    <= NB_W'(16);
            is_init  <= 1'b1;
            is_read  <= 1'b0;
            div_cnt  <= '0;
            spi_cs_n <= 1'b0;
            state    <= S_CS_SETUP;
          end else begin
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            is_init       <= 1'b0;
            is_read       <= ~bus.req_we;
            if (bus.req_we && !mask_legal) begin
              state <= S_REJECT;
            end else begin
              sr       <= frame;
              nbits    <= frame_bits;
              div_cnt  <= '0;
              spi_cs_n <= 1'b0;
              state    <= S_CS_SETUP;
            end
          end
        end

        S_CS_SETUP: begin
          if (div_last) begin
            div_cnt  <= '0;
            spi_mosi <= sr[SR_W-1];
            state    <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              rx      <= {rx[30:0], spi_miso};
            end else begin
              spi_clk <= 1'b0;
              if (nbits == NB_W'(1)) begin
                spi_mosi <= 1'b0;
                state    <= S_CS_HOLD;
              end else begin
                nbits    <= nbits - NB_W'(1);
                sr       <= {sr[SR_W-2:0], 1'b0};
                spi_mosi <= sr[SR_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_CS_HOLD: begin
          if (div_last) begin
            div_cnt  <= '0;
            spi_cs_n <= 1'b1;
            if (is_init) begin
              gap_cnt <= GAP_W'(CS_GAP - 1);
              state   <= S_GAP;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              // First byte on the wire is the lowest-addressed byte.
              if (is_read)
                bus.rsp_rdata <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
              state <= S_RESP;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_REJECT: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b1;
          state         <= S_RESP;
        end

        S_RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          gap_cnt       <= GAP_W'(CS_GAP - 1);
          state         <= S_GAP;
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          spi_cs_n      <= 1'b1;
          spi_clk       <= 1'b0;
          bus.req_ready <= 1'b0;
          state         <= S_INIT;
        end
      endcase
    end
  end

endmodule
